// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry registered elastic stage with valid/ready on both sides
// Both ready and valid come from flops, so m_ready_i never reaches s_ready_o combinationally.
module skid_buffer #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [Width-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [Width-1:0] m_data_o,
  output logic [1:0]       occupancy_o
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StBusy  = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [Width-1:0] out_q, out_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             s_ready_q;
  logic             m_valid_q;
  logic             up_xfer;
  logic             dn_xfer;

  assign up_xfer = s_valid_i & s_ready_q;
  assign dn_xfer = m_valid_q & m_ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (up_xfer) begin
          out_d   = s_data_i;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (up_xfer && dn_xfer) begin
          out_d = s_data_i;
        end else if (up_xfer) begin
          skid_d  = s_data_i;
          state_d = StFull;
        end else if (dn_xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // The skid word is always younger than out, so it moves up on a drain.
        if (dn_xfer) begin
          out_d   = skid_q;
          state_d = StBusy;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StEmpty;
      out_q     <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      s_ready_q <= (state_d != StFull);
      m_valid_q <= (state_d != StEmpty);
    end
  end

  assign s_ready_o   = s_ready_q;
  assign m_valid_o   = m_valid_q;
  assign m_data_o    = out_q;
  assign occupancy_o = state_q;

endmodule

// File: tb/tb_skid_buffer.sv
// tb/tb_skid_buffer.sv - directed and randomized bench for skid_buffer
// Reference model: a bounded FIFO queue of held words, capacity two.
module tb_skid_buffer;

  logic        clk;
  logic        rst_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [15:0] s_data_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [15:0] m_data_o;
  logic [1:0]  occupancy_o;

  skid_buffer #(.Width(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .occupancy_o (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passed;
  int unsigned total;
  logic [15:0] q[$];
  logic        rdy_ok;
  logic        in_rst;
  int unsigned sent_cnt;
  int unsigned recv_cnt;
  logic [15:0] sent_log[$];
  int unsigned recv_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_model();
    check("valid", {31'd0, m_valid_o}, {31'd0, q.size() > 0});
    check("ready", {31'd0, s_ready_o}, {31'd0, rdy_ok && (q.size() < 2)});
    check("occupancy", {30'd0, occupancy_o}, q.size());
    if (q.size() > 0) check("data", {16'd0, m_data_o}, {16'd0, q[0]});
    else if (in_rst) check("rst_data", {16'd0, m_data_o}, 32'd0);
  endtask

  // Drive at the falling edge, update the model at the rising edge, check at the next fall.
  task automatic cycle(input logic r, input logic sv, input logic [15:0] sd, input logic mr);
    logic acc;
    logic dr;
    rst_i     = r;
    s_valid_i = sv;
    s_data_i  = sd;
    m_ready_i = mr;
    @(posedge clk);
    if (r) begin
      q.delete();
      rdy_ok = 1'b0;
      in_rst = 1'b1;
    end else begin
      acc = sv && rdy_ok && (q.size() < 2);
      dr  = (q.size() > 0) && mr;
      if (dr) begin
        if (recv_idx < sent_log.size()) begin
          check("scoreboard", {16'd0, m_data_o}, {16'd0, sent_log[recv_idx]});
          recv_idx++;
        end
        recv_cnt++;
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(sd);
        sent_cnt++;
      end
      rdy_ok = 1'b1;
      in_rst = 1'b0;
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [15:0] prev_data;
    logic        prev_stall;
    logic        sv;
    logic        mr;
    int unsigned cycles;
    passed   = 0;
    total    = 0;
    rdy_ok   = 1'b0;
    in_rst   = 1'b1;
    sent_cnt = 0;
    recv_cnt = 0;
    recv_idx = 0;
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = 16'h0;
    m_ready_i = 1'b0;
    @(negedge clk);

    // Reset release
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
      check("rst_valid", {31'd0, m_valid_o}, 32'd0);
      check("rst_ready", {31'd0, s_ready_o}, 32'd0);
    end
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("release_ready", {31'd0, s_ready_o}, 32'd1);

    // Streaming
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 16'(i), 1'b1);
      check("stream_data", {16'd0, m_data_o}, i);
      check("stream_occ", {30'd0, occupancy_o}, 32'd1);
      check("stream_ready", {31'd0, s_ready_o}, 32'd1);
    end
    cycle(1'b0, 1'b0, 16'h0, 1'b1);

    // Skid fill and drain
    cycle(1'b0, 1'b1, 16'h00A1, 1'b0);
    cycle(1'b0, 1'b1, 16'h00A2, 1'b0);
    check("fill_occ", {30'd0, occupancy_o}, 32'd2);
    check("fill_ready", {31'd0, s_ready_o}, 32'd0);
    check("fill_data", {16'd0, m_data_o}, 32'h00A1);
    cycle(1'b0, 1'b1, 16'h00A3, 1'b0);
    check("ignored_data", {16'd0, m_data_o}, 32'h00A1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("drain1_data", {16'd0, m_data_o}, 32'h00A2);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("drain2_valid", {31'd0, m_valid_o}, 32'd0);

    // Drain to empty
    cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    check("busy_data", {16'd0, m_data_o}, 32'h1234);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("empty_valid", {31'd0, m_valid_o}, 32'd0);
    check("empty_occ", {30'd0, occupancy_o}, 32'd0);

    // Reset mid-operation
    cycle(1'b0, 1'b1, 16'h0BAD, 1'b0);
    cycle(1'b0, 1'b1, 16'h0BEE, 1'b0);
    check("pre_rst_occ", {30'd0, occupancy_o}, 32'd2);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    check("mid_rst_valid", {31'd0, m_valid_o}, 32'd0);
    check("mid_rst_occ", {30'd0, occupancy_o}, 32'd0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("post_rst_valid", {31'd0, m_valid_o}, 32'd0);
    cycle(1'b0, 1'b1, 16'h0C01, 1'b1);
    check("post_rst_data", {16'd0, m_data_o}, 32'h0C01);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("post_rst_empty", {31'd0, m_valid_o}, 32'd0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("post_rst_still_empty", {31'd0, m_valid_o}, 32'd0);

    // Random stalls with scoreboard
    sent_cnt = 0;
    recv_cnt = 0;
    sent_log.delete();
    recv_idx = 0;
    cycles = 0;
    while (sent_cnt < 1000 && cycles < 20000) begin
      logic [15:0] d;
      sv = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1));
      d  = 16'($urandom);
      prev_stall = m_valid_o && !mr;
      prev_data  = m_data_o;
      if (sv && s_ready_o) sent_log.push_back(d);
      cycle(1'b0, sv, d, mr);
      if (prev_stall) check("stall_stable", {16'd0, m_data_o}, {16'd0, prev_data});
      cycles++;
    end
    check("rand_sent_bound", sent_cnt, 32'd1000);
    cycles = 0;
    while (q.size() > 0 && cycles < 10) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      cycles++;
    end
    check("rand_recv_count", recv_cnt, 32'd1000);
    check("rand_final_occ", {30'd0, occupancy_o}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
- Two-entry elastic pipeline stage with a valid/ready handshake on both sides.
- Sits between a producer and the enabled data-register stages of the DWT/coefficient datapath.
- Registers both the data path and the upstream ready, so back-pressure never forms a combinational path through the stage.
- Sustains one transfer per clock with no bubbles and no loss or duplication under any stall pattern.

Parameters:
- Width, 16, data word width in bits (>=1).

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  synchronous active-high reset.
- s_valid_i  input  1  upstream word valid.
- s_ready_o  output  1  stage can accept a word this cycle (registered).
- s_data_i  input  Width  upstream word.
- m_valid_o  output  1  m_data_o holds a valid word (registered).
- m_ready_i  input  1  downstream accepts m_data_o this cycle.
- m_data_o  output  Width  output word (registered).
- occupancy_o  output  2  number of words held: 0, 1 or 2.

Behaviour:
- Transfers: upstream transfer = s_valid_i & s_ready_o at a rising edge; downstream transfer = m_valid_o & m_ready_i at a rising edge.
- Storage: output register (out) drives m_data_o; skid register (skid) is internal.
- Reset (rst_i high at an edge):
  - state=EMPTY; m_valid_o=0, s_ready_o=0, m_data_o=0, skid=0, occupancy_o=0.
  - s_ready_o rises to 1 at the first edge with rst_i low.
  - Reset mid-operation discards all held words; nothing is emitted afterwards.
- States:
  - EMPTY: occupancy 0, m_valid_o=0, s_ready_o=1.
    - Upstream transfer -> out<=s_data_i, go BUSY.
    - Otherwise stay.
  - BUSY: occupancy 1, m_valid_o=1, s_ready_o=1.
    - Upstream and downstream transfer -> out<=s_data_i, stay BUSY (full throughput).
    - Upstream only -> skid<=s_data_i, go FULL, s_ready_o<=0.
    - Downstream only -> go EMPTY, m_valid_o<=0.
    - Neither -> hold.
  - FULL: occupancy 2, m_valid_o=1, s_ready_o=0.
    - Downstream transfer -> out<=skid, go BUSY, s_ready_o<=1.
    - Otherwise hold.
    - s_valid_i and s_data_i are ignored while s_ready_o=0.
- Latency: a word accepted at edge N appears on m_data_o with m_valid_o=1 after edge N (one cycle) when the stage was EMPTY or BUSY with a drain.
- Ordering: strict FIFO; out is always older than skid.
- Stability rules:
  - m_data_o and m_valid_o change only on a downstream transfer, on a fill from EMPTY, or on reset.
  - While m_valid_o=1 and m_ready_i=0, m_data_o is stable.
  - m_valid_o never drops without a downstream transfer, except on reset.
- Ready timing: s_ready_o is a function of the registered state only; m_ready_i has no combinational path to s_ready_o.
- Occupancy: occupancy_o equals the state encoding and is registered; it never reads 3.
- Unused skid contents are don't-care but must not reach m_data_o.
- Width rule: data is passed through bit-exact, with no sign or zero extension.

Test Plan:
- Reset release: hold rst_i 3 cycles, then release -> m_valid_o=0, occupancy_o=0, m_data_o=0 throughout reset; s_ready_o=1 at the first cycle after release.
- Streaming: m_ready_i=1, drive 0x0001..0x0008 on consecutive cycles -> m_data_o shows 0x0001..0x0008 one cycle later, m_valid_o continuous, occupancy_o stays 1, s_ready_o stays 1.
- Skid fill: m_ready_i=0, send 0x00A1 then 0x00A2 -> occupancy_o=2, s_ready_o=0, m_data_o=0x00A1.
  - Presenting 0x00A3 while s_ready_o=0 is ignored.
  - Raising m_ready_i for 2 cycles drains 0x00A1, then 0x00A2.
- Random stalls: 1000 random words with 50% random s_valid_i and m_ready_i -> scoreboard shows in-order, no loss or duplication, m_data_o stable during every stall, occupancy_o never 3.
- Drain to empty: BUSY holding 0x1234, s_valid_i=0, m_ready_i=1 -> 0x1234 transferred, next cycle m_valid_o=0, occupancy_o=0.
- Reset mid-operation: FULL with 0x0BAD/0x0BEE, pulse rst_i 1 cycle -> m_valid_o=0, occupancy_o=0; neither word ever appears; the next word sent, 0x0C01, emerges alone.
